// File: rtl/ccip_rd_arbiter_if.sv
// Bundled request, c0 Tx/Rx and routed-response signals of the CCI-P read arbiter.
// The arbiter connects through the slave modport; its environment uses the master modport.
interface ccip_rd_arbiter_if;
  logic         req0_valid;
  logic [41:0]  req0_address;
  logic         req0_ready;
  logic         req1_valid;
  logic [41:0]  req1_address;
  logic         req1_ready;

  logic         rd_req_valid;
  logic [41:0]  rd_req_address;
  logic [15:0]  rd_req_mdata;
  logic         rd_req_alm_full;

  logic         rd_rsp_valid;
  logic [15:0]  rd_rsp_mdata;
  logic [511:0] rd_rsp_data;

  logic         rsp0_valid;
  logic         rsp1_valid;
  logic [511:0] rsp_data;
  logic [14:0]  rsp_tag;
  logic         err_unexpected_rsp;

  logic [31:0]  grant_cnt0;
  logic [31:0]  grant_cnt1;
  logic [31:0]  stall_cnt;

  modport slave (
    input  req0_valid, req0_address, req1_valid, req1_address,
    input  rd_req_alm_full, rd_rsp_valid, rd_rsp_mdata, rd_rsp_data,
    output req0_ready, req1_ready,
    output rd_req_valid, rd_req_address, rd_req_mdata,
    output rsp0_valid, rsp1_valid, rsp_data, rsp_tag, err_unexpected_rsp,
    output grant_cnt0, grant_cnt1, stall_cnt
  );

  modport master (
    output req0_valid, req0_address, req1_valid, req1_address,
    output rd_req_alm_full, rd_rsp_valid, rd_rsp_mdata, rd_rsp_data,
    input  req0_ready, req1_ready,
    input  rd_req_valid, rd_req_address, rd_req_mdata,
    input  rsp0_valid, rsp1_valid, rsp_data, rsp_tag, err_unexpected_rsp,
    input  grant_cnt0, grant_cnt1, stall_cnt
  );
endinterface

// File: rtl/ccip_rd_arbiter.sv
// Two-requester round-robin CCI-P read arbiter: grant -> c0 Tx one cycle later, responses routed one cycle later.
// Grants stall on alm_full or per-requester outstanding limit; responses never stall. Stats under CCIP_RD_ARB_STATS_EN.
module ccip_rd_arbiter #(
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic              clk,
  input  logic              reset,
  ccip_rd_arbiter_if.slave  bus
);

  localparam logic [6:0] MAX_OUT = 7'(MAX_OUTSTANDING);

  logic [6:0]  outst0, outst1;
  logic [14:0] seq0, seq1;
  logic        last1;
  logic        elig0, elig1;
  logic        grant0, grant1;
  logic        hit0, hit1;

  function automatic logic [6:0] next_outst(input logic [6:0] cur, input logic inc, input logic dec);
    logic [6:0] nxt;
    nxt = cur;
    if (inc && !dec)
      nxt = cur + 7'd1;
    else if (dec && !inc && cur != 7'd0)
      nxt = cur - 7'd1;
    return nxt;
  endfunction

  // last1 high means requester 1 was granted last, so requester 0 wins a tie
  always_comb begin
    elig0  = !reset && !bus.rd_req_alm_full && bus.req0_valid && (outst0 < MAX_OUT);
    elig1  = !reset && !bus.rd_req_alm_full && bus.req1_valid && (outst1 < MAX_OUT);
    grant0 = elig0 && (!elig1 || last1);
    grant1 = elig1 && (!elig0 || !last1);
    hit0   = bus.rd_rsp_valid && !bus.rd_rsp_mdata[0];
    hit1   = bus.rd_rsp_valid &&  bus.rd_rsp_mdata[0];
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.rd_req_valid       <= 1'b0;
      bus.rd_req_address     <= '0;
      bus.rd_req_mdata       <= '0;
      bus.rsp0_valid         <= 1'b0;
      bus.rsp1_valid         <= 1'b0;
      bus.rsp_data           <= '0;
      bus.rsp_tag            <= '0;
      bus.err_unexpected_rsp <= 1'b0;
      outst0                 <= '0;
      outst1                 <= '0;
      seq0                   <= '0;
      seq1                   <= '0;
      last1                  <= 1'b1;
    end else begin
      bus.rd_req_valid <= grant0 || grant1;
      if (grant0) begin
        bus.rd_req_address <= bus.req0_address;
        bus.rd_req_mdata   <= {seq0, 1'b0};
        seq0               <= seq0 + 15'd1;
        last1              <= 1'b0;
      end else if (grant1) begin
        bus.rd_req_address <= bus.req1_address;
        bus.rd_req_mdata   <= {seq1, 1'b1};
        seq1               <= seq1 + 15'd1;
        last1              <= 1'b1;
      end

      bus.rsp0_valid <= hit0;
      bus.rsp1_valid <= hit1;
      if (bus.rd_rsp_valid) begin
        bus.rsp_data <= bus.rd_rsp_data;
        bus.rsp_tag  <= bus.rd_rsp_mdata[15:1];
      end
      if ((hit0 && outst0 == 7'd0) || (hit1 && outst1 == 7'd0))
        bus.err_unexpected_rsp <= 1'b1;

      outst0 <= next_outst(outst0, grant0, hit0);
      outst1 <= next_outst(outst1, grant1, hit1);
    end
  end

`ifdef CCIP_RD_ARB_STATS_EN
  logic stall;
  assign stall = (bus.req0_valid || bus.req1_valid) && !grant0 && !grant1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.grant_cnt0 <= '0;
      bus.grant_cnt1 <= '0;
      bus.stall_cnt  <= '0;
    end else begin
      if (grant0) bus.grant_cnt0 <= bus.grant_cnt0 + 32'd1;
      if (grant1) bus.grant_cnt1 <= bus.grant_cnt1 + 32'd1;
      if (stall)  bus.stall_cnt  <= bus.stall_cnt + 32'd1;
    end
  end
`else
  assign bus.grant_cnt0 = '0;
  assign bus.grant_cnt1 = '0;
  assign bus.stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_ccip_rd_arbiter.sv
// Scoreboard bench for ccip_rd_arbiter: a reference model predicts grants and queues expected c0 Tx / response outputs.
module tb_ccip_rd_arbiter;
  localparam int MAXO = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ccip_rd_arbiter_if bus();

  ccip_rd_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct { logic [41:0] addr; logic [15:0] mdata; } req_exp_t;
  typedef struct { logic id; logic [14:0] tag; logic [511:0] data; } rsp_exp_t;

  req_exp_t req_q[$];
  rsp_exp_t rsp_q[$];

  int          m_out [2];
  logic [14:0] m_seq [2];
  logic        m_last1;
  logic        m_err;
  logic [31:0] m_gcnt [2];
  logic [31:0] m_stall;

  // Reference model: outputs registered last cycle are checked first, then this cycle's inputs are evaluated.
  always @(negedge clk) begin
    logic e0, e1, g0, g1, h0, h1, exp_v;
    req_exp_t er;
    rsp_exp_t ep;
    if (reset) begin
      check("rst_rdy0", bus.req0_ready, 1'b0);
      check("rst_rdy1", bus.req1_ready, 1'b0);
      check("rst_rdvld", bus.rd_req_valid, 1'b0);
      check("rst_addr", bus.rd_req_address, 42'h0);
      check("rst_mdata", bus.rd_req_mdata, 16'h0);
      check("rst_rsp", {bus.rsp0_valid, bus.rsp1_valid, bus.err_unexpected_rsp}, 3'b000);
      check("rst_tag", bus.rsp_tag, 15'h0);
      check("rst_data", bus.rsp_data, 512'h0);
      req_q.delete();
      rsp_q.delete();
      m_out[0] = 0; m_out[1] = 0; m_seq[0] = '0; m_seq[1] = '0;
      m_last1 = 1'b1; m_err = 1'b0;
      m_gcnt[0] = '0; m_gcnt[1] = '0; m_stall = '0;
    end else begin
      exp_v = (req_q.size() > 0);
      check("rd_vld", bus.rd_req_valid, exp_v);
      if (exp_v) begin
        er = req_q.pop_front();
        check("rd_addr", bus.rd_req_address, er.addr);
        check("rd_mdata", bus.rd_req_mdata, er.mdata);
      end
      exp_v = (rsp_q.size() > 0);
      ep = '{id: 1'b0, tag: '0, data: '0};
      if (exp_v) ep = rsp_q.pop_front();
      check("rsp0_vld", bus.rsp0_valid, exp_v && !ep.id);
      check("rsp1_vld", bus.rsp1_valid, exp_v && ep.id);
      if (exp_v) begin
        check("rsp_tag", bus.rsp_tag, ep.tag);
        check("rsp_data", bus.rsp_data, ep.data);
      end
      check("err", bus.err_unexpected_rsp, m_err);
`ifdef CCIP_RD_ARB_STATS_EN
      check("gcnt0", bus.grant_cnt0, m_gcnt[0]);
      check("gcnt1", bus.grant_cnt1, m_gcnt[1]);
      check("stall", bus.stall_cnt, m_stall);
`else
      check("stats0", {bus.grant_cnt0, bus.grant_cnt1, bus.stall_cnt}, 96'h0);
`endif

      e0 = bus.req0_valid && !bus.rd_req_alm_full && (m_out[0] < MAXO);
      e1 = bus.req1_valid && !bus.rd_req_alm_full && (m_out[1] < MAXO);
      g0 = e0 && (!e1 || m_last1);
      g1 = e1 && (!e0 || !m_last1);
      check("rdy0", bus.req0_ready, g0);
      check("rdy1", bus.req1_ready, g1);
      if (g0) begin
        req_q.push_back('{addr: bus.req0_address, mdata: {m_seq[0], 1'b0}});
        m_seq[0]++; m_last1 = 1'b0; m_gcnt[0]++;
      end
      if (g1) begin
        req_q.push_back('{addr: bus.req1_address, mdata: {m_seq[1], 1'b1}});
        m_seq[1]++; m_last1 = 1'b1; m_gcnt[1]++;
      end
      if ((bus.req0_valid || bus.req1_valid) && !g0 && !g1) m_stall++;

      h0 = bus.rd_rsp_valid && !bus.rd_rsp_mdata[0];
      h1 = bus.rd_rsp_valid &&  bus.rd_rsp_mdata[0];
      if (bus.rd_rsp_valid)
        rsp_q.push_back('{id: bus.rd_rsp_mdata[0], tag: bus.rd_rsp_mdata[15:1], data: bus.rd_rsp_data});
      if ((h0 && m_out[0] == 0) || (h1 && m_out[1] == 0)) m_err = 1'b1;
      if (g0 && !h0) m_out[0]++; else if (h0 && !g0 && m_out[0] > 0) m_out[0]--;
      if (g1 && !h1) m_out[1]++; else if (h1 && !g1 && m_out[1] > 0) m_out[1]--;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_address = '0;
    bus.req1_valid = 1'b0; bus.req1_address = '0;
    bus.rd_req_alm_full = 1'b0;
    bus.rd_rsp_valid = 1'b0; bus.rd_rsp_mdata = '0; bus.rd_rsp_data = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int cnt;
    logic [5:0] order;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Single requester: same-cycle ready, next-cycle c0 Tx, sequence advances by one per grant
    bus.req0_valid = 1'b1; bus.req0_address = 42'h100;
    @(negedge clk); check("r35_rdy0", bus.req0_ready, 1'b1);
    tick(); bus.req0_valid = 1'b0;
    @(negedge clk);
    check("r35_vld", bus.rd_req_valid, 1'b1);
    check("r35_addr", bus.rd_req_address, 42'h100);
    check("r35_md0", bus.rd_req_mdata, 16'h0000);
    tick(); bus.req0_valid = 1'b1; bus.req0_address = 42'h140;
    tick(); bus.req0_valid = 1'b0;
    @(negedge clk); check("r35_md1", bus.rd_req_mdata, 16'h0002);
    tick();

    // Round-robin alternation
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_address = 42'hA00;
    bus.req1_valid = 1'b1; bus.req1_address = 42'hB00;
    order = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); order[i] = bus.req1_ready;
      tick();
    end
    check("r36_order", order, 6'b101010);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    tick();

    // Almost-full blocks all grants; first grant lands as it falls
    do_reset();
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; bus.rd_req_alm_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); check("r37_blk", {bus.req0_ready, bus.req1_ready}, 2'b00);
      tick();
    end
    bus.rd_req_alm_full = 1'b0;
    @(negedge clk); check("r37_first", {bus.req0_ready, bus.req1_ready}, 2'b10);
    tick();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    tick();

    // Outstanding limit on requester 1, then release by a response
    do_reset();
    bus.req1_valid = 1'b1; bus.req1_address = 42'h3_0000;
    cnt = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); cnt += int'(bus.req1_ready);
      tick();
    end
    check("r38_cnt", cnt, 4);
    check("r38_blk", bus.req1_ready, 1'b0);
    bus.rd_rsp_valid = 1'b1; bus.rd_rsp_mdata = 16'h0003; bus.rd_rsp_data = {16{32'hC0DE_0001}};
    tick();
    bus.rd_rsp_valid = 1'b0;
    @(negedge clk);
    check("r38_rsp1", bus.rsp1_valid, 1'b1);
    check("r38_tag", bus.rsp_tag, 15'd1);
    check("r38_again", bus.req1_ready, 1'b1);
    tick();
    bus.req1_valid = 1'b0;
    tick();

    // Unexpected response is sticky; simultaneous grant and response keep the count
    do_reset();
    bus.rd_rsp_valid = 1'b1; bus.rd_rsp_mdata = 16'h0000; bus.rd_rsp_data = {16{32'h5A5A_A5A5}};
    tick(); bus.rd_rsp_valid = 1'b0;
    @(negedge clk);
    check("r39_rsp0", bus.rsp0_valid, 1'b1);
    check("r39_err", bus.err_unexpected_rsp, 1'b1);
    tick(); tick();
    @(negedge clk); check("r39_sticky", bus.err_unexpected_rsp, 1'b1);
    bus.req0_valid = 1'b1; bus.req0_address = 42'h200;
    tick();
    bus.rd_rsp_valid = 1'b1; bus.rd_rsp_mdata = 16'h0000;
    tick();
    bus.rd_rsp_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); cnt += int'(bus.req0_ready);
      tick();
    end
    check("r39_left", cnt, 3);
    bus.req0_valid = 1'b0;
    tick();

    // Statistics: 10 grants to requester 0, then 3 stalled cycles
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_address = 42'h400;
    tick();
    bus.rd_rsp_valid = 1'b1; bus.rd_rsp_mdata = 16'h0000;
    for (int i = 0; i < 9; i++) tick();
    bus.rd_rsp_valid = 1'b0; bus.rd_req_alm_full = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    bus.req0_valid = 1'b0; bus.rd_req_alm_full = 1'b0;
    @(negedge clk);
`ifdef CCIP_RD_ARB_STATS_EN
    check("r40_gcnt0", bus.grant_cnt0, 32'd10);
    check("r40_stall", bus.stall_cnt, 32'd3);
`else
    check("r40_gcnt0", bus.grant_cnt0, 32'd0);
    check("r40_stall", bus.stall_cnt, 32'd0);
`endif
    check("r40_gcnt1", bus.grant_cnt1, 32'd0);
    tick();

    // Random traffic checked entirely by the model, with a mid-run reset
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      bus.req0_valid      = 1'($urandom_range(0, 1));
      bus.req0_address    = {10'($urandom), 32'($urandom)};
      bus.req1_valid      = 1'($urandom_range(0, 1));
      bus.req1_address    = {10'($urandom), 32'($urandom)};
      bus.rd_req_alm_full = ($urandom_range(0, 4) == 0);
      bus.rd_rsp_valid    = 1'($urandom_range(0, 1));
      bus.rd_rsp_mdata    = 16'($urandom);
      for (int w = 0; w < 16; w++) bus.rd_rsp_data[w*32 +: 32] = $urandom;
      tick();
    end
    idle_inputs();
    tick();
    tick();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
